// File: rtl/silencer_pkg.sv
// Shared types, latency constant and remainder step for the step silencer.
package silencer_pkg;

    localparam int WIDTH = 13;
    localparam int LAT   = WIDTH + 4;

    typedef logic [WIDTH-1:0]      value_t;
    typedef logic signed [WIDTH:0] diff_t;

    // One restoring-division step: shift in the next dividend bit, subtract C if it fits.
    // Assumes r < c, so the result also stays below c.
    function automatic value_t rem_step(input value_t r, input logic b, input value_t c);
        logic [WIDTH:0] sh;
        sh = {r, b};
        if (sh >= {1'b0, c}) begin
            return value_t'(sh - {1'b0, c});
        end
        return sh[WIDTH-1:0];
    endfunction

endpackage

// File: rtl/silencer_mod_pipe.sv
// Pipelined unsigned remainder a mod c, one dividend bit per stage, WIDTH stages deep.
module silencer_mod_pipe
    import silencer_pkg::*;
(
    input  logic   clk_i,
    input  value_t a_i,
    input  value_t c_i,
    output value_t rem_o
);

    value_t r_q [WIDTH];
    value_t a_q [WIDTH-1];
    value_t c_q [WIDTH-1];

    always_ff @(posedge clk_i) begin
        r_q[0] <= rem_step('0, a_i[WIDTH-1], c_i);
        a_q[0] <= a_i;
        c_q[0] <= c_i;
        for (int k = 1; k < WIDTH; k++) begin
            r_q[k] <= rem_step(r_q[k-1], a_q[k-1][WIDTH-1-k], c_q[k-1]);
        end
        for (int k = 1; k < WIDTH-1; k++) begin
            a_q[k] <= a_q[k-1];
            c_q[k] <= c_q[k-1];
        end
    end

    assign rem_o = r_q[WIDTH-1];

endmodule

// File: rtl/step_silencer.sv
// Per-transducer slew limiter: duty moves linearly, phase moves the short way round modulo CYCLE.
module step_silencer
    import silencer_pkg::*;
#(
    parameter int DEPTH = 249
) (
    input  logic   CLK,
    input  logic   RST,
    input  logic   DIN_VALID,
    input  value_t STEP,
    input  value_t CYCLE [DEPTH],
    input  value_t DUTY,
    input  value_t PHASE,
    output value_t DUTY_S,
    output value_t PHASE_S,
    output logic   DOUT_VALID
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef logic [IW-1:0] idx_t;
    localparam idx_t LAST_IDX = idx_t'(DEPTH - 1);

    typedef struct packed {
        logic   valid;
        idx_t   idx;
        value_t step;
        value_t cycle;
        value_t cur_duty;
        value_t tgt_duty;
    } side_t;

    // Stream protocol: no backpressure; a sample is taken on every cycle DIN_VALID is high
    // and emitted exactly LAT cycles later with DOUT_VALID high.
    value_t state_duty_q  [DEPTH];
    value_t state_phase_q [DEPTH];
    idx_t   idx_q;
    side_t  ent_q;
    value_t ent_cur_phase_q, ent_tgt_phase_q;
    side_t  side_q [WIDTH];
    value_t cur_mod, tgt_mod;
    side_t  mod_side;
    value_t f_d;
    side_t  b_side_q;
    value_t b_cmod_q, b_tmod_q, b_f_q;
    diff_t  duty_diff, duty_mag;
    value_t duty_d, phase_d, back_dist;
    logic [WIDTH:0] fwd_sum;
    logic   upd_valid_q;
    idx_t   upd_idx_q;
    value_t upd_duty_q, upd_phase_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_q       <= '0;
            ent_q.valid <= 1'b0;
        end else begin
            ent_q <= '{valid: DIN_VALID, idx: idx_q, step: STEP, cycle: CYCLE[idx_q],
                       cur_duty: state_duty_q[idx_q], tgt_duty: DUTY};
            ent_cur_phase_q <= state_phase_q[idx_q];
            ent_tgt_phase_q <= PHASE;
            if (DIN_VALID) begin
                idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + idx_t'(1);
            end else begin
                idx_q <= '0;
            end
        end
    end

    silencer_mod_pipe u_cur_mod (.clk_i(CLK), .a_i(ent_cur_phase_q), .c_i(ent_q.cycle), .rem_o(cur_mod));
    silencer_mod_pipe u_tgt_mod (.clk_i(CLK), .a_i(ent_tgt_phase_q), .c_i(ent_q.cycle), .rem_o(tgt_mod));

    // Sideband rides alongside the remainder pipes so it lines up with their results.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < WIDTH; k++) side_q[k].valid <= 1'b0;
        end else begin
            side_q[0] <= ent_q;
            for (int k = 1; k < WIDTH; k++) side_q[k] <= side_q[k-1];
        end
    end

    assign mod_side = side_q[WIDTH-1];
    assign f_d = (tgt_mod >= cur_mod) ? tgt_mod - cur_mod
                                      : mod_side.cycle - (cur_mod - tgt_mod);

    always_comb begin
        duty_diff = diff_t'({1'b0, b_side_q.tgt_duty}) - diff_t'({1'b0, b_side_q.cur_duty});
        duty_mag  = (duty_diff < 0) ? -duty_diff : duty_diff;
        if (duty_mag <= diff_t'({1'b0, b_side_q.step})) begin
            duty_d = b_side_q.tgt_duty;
        end else if (duty_diff < 0) begin
            duty_d = b_side_q.cur_duty - b_side_q.step;
        end else begin
            duty_d = b_side_q.cur_duty + b_side_q.step;
        end

        fwd_sum   = {1'b0, b_cmod_q} + {1'b0, b_side_q.step};
        back_dist = b_side_q.cycle - b_f_q;
        if (b_f_q == '0) begin
            phase_d = b_tmod_q;
        end else if (b_f_q <= (b_side_q.cycle >> 1)) begin
            if (b_f_q <= b_side_q.step) begin
                phase_d = b_tmod_q;
            end else if (fwd_sum >= {1'b0, b_side_q.cycle}) begin
                phase_d = value_t'(fwd_sum - {1'b0, b_side_q.cycle});
            end else begin
                phase_d = fwd_sum[WIDTH-1:0];
            end
        end else begin
            if (back_dist <= b_side_q.step) begin
                phase_d = b_tmod_q;
            end else if (b_cmod_q >= b_side_q.step) begin
                phase_d = b_cmod_q - b_side_q.step;
            end else begin
                phase_d = b_cmod_q + (b_side_q.cycle - b_side_q.step);
            end
        end
    end

    // Write-back lands LAT cycles after the read; the same index cannot re-enter sooner.
    always_ff @(posedge CLK) begin
        if (RST) begin
            b_side_q.valid <= 1'b0;
            upd_valid_q    <= 1'b0;
            DOUT_VALID     <= 1'b0;
            DUTY_S         <= '0;
            PHASE_S        <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                state_duty_q[k]  <= '0;
                state_phase_q[k] <= '0;
            end
        end else begin
            b_side_q    <= mod_side;
            b_cmod_q    <= cur_mod;
            b_tmod_q    <= tgt_mod;
            b_f_q       <= f_d;
            upd_valid_q <= b_side_q.valid;
            upd_idx_q   <= b_side_q.idx;
            upd_duty_q  <= duty_d;
            upd_phase_q <= phase_d;
            DOUT_VALID  <= upd_valid_q;
            if (upd_valid_q) begin
                DUTY_S                   <= upd_duty_q;
                PHASE_S                  <= upd_phase_q;
                state_duty_q[upd_idx_q]  <= upd_duty_q;
                state_phase_q[upd_idx_q] <= upd_phase_q;
            end
        end
    end

endmodule

// File: tb/tb_step_silencer.sv
// Directed bench for step_silencer: frame driver, output monitor, immediate-assertion checks.
module tb_step_silencer;
    import silencer_pkg::*;

    localparam int DEPTH   = 249;
    localparam int EXP_LAT = 17;

    logic   clk = 1'b0;
    logic   rst;
    logic   din_valid;
    value_t step;
    value_t cycle [DEPTH];
    value_t duty, phase;
    value_t duty_s, phase_s;
    logic   dout_valid;

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;
    int t_in     = 0;

    value_t tgt_duty [DEPTH];
    value_t tgt_phase [DEPTH];
    value_t cap_duty [DEPTH];
    value_t cap_phase [DEPTH];
    int     oidx        = 0;
    int     run_len     = 0;
    int     first_rise  = 0;
    int     valid_total = 0;
    logic   prev_v      = 1'b0;

    step_silencer #(.DEPTH(DEPTH)) dut (
        .CLK(clk), .RST(rst), .DIN_VALID(din_valid), .STEP(step), .CYCLE(cycle),
        .DUTY(duty), .PHASE(phase), .DUTY_S(duty_s), .PHASE_S(phase_s),
        .DOUT_VALID(dout_valid)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    // Output monitor: captures the most recent frame and the current valid run
    always @(negedge clk) begin
        if (dout_valid) begin
            if (!prev_v) begin
                first_rise = cyc_cnt;
                run_len    = 0;
            end
            cap_duty[oidx]  = duty_s;
            cap_phase[oidx] = phase_s;
            oidx = (oidx == DEPTH-1) ? 0 : oidx + 1;
            run_len++;
            valid_total++;
        end else begin
            oidx = 0;
        end
        prev_v = dout_valid;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frames(input int n);
        for (int f = 0; f < n; f++) begin
            for (int i = 0; i < DEPTH; i++) begin
                @(negedge clk);
                if (f == 0 && i == 0) t_in = cyc_cnt;
                din_valid = 1'b1;
                duty      = tgt_duty[i];
                phase     = tgt_phase[i];
            end
        end
        @(negedge clk);
        din_valid = 1'b0;
        idle(EXP_LAT + 3);
    endtask

    task automatic set_cycle(input int c);
        for (int i = 0; i < DEPTH; i++) cycle[i] = value_t'(c);
    endtask

    task automatic frame_check(input string tag, input int st, input int d, input int p,
                               input int exp_d, input int exp_p);
        int bad;
        step = value_t'(st);
        for (int i = 0; i < DEPTH; i++) begin
            tgt_duty[i]  = value_t'(d);
            tgt_phase[i] = value_t'(p);
        end
        send_frames(1);
        check({tag, "_duty0"}, int'(cap_duty[0]), exp_d);
        check({tag, "_phase0"}, int'(cap_phase[0]), exp_p);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(cap_duty[i]) != exp_d || int'(cap_phase[i]) != exp_p) bad++;
        end
        check({tag, "_all_bad"}, bad, 0);
    endtask

    initial begin
        int bad_d, bad_p, snap;
        rst = 1'b1;
        din_valid = 1'b0;
        step = '0;
        duty = '0;
        phase = '0;
        set_cycle(2000);
        idle(3);
        check("reset_valid", int'(dout_valid), 0);
        check("reset_duty", int'(duty_s), 0);
        check("reset_phase", int'(phase_s), 0);
        rst = 1'b0;
        idle(2);

        // Convergence: 41 back-to-back frames at STEP=100 reach every target
        step = value_t'(100);
        for (int i = 0; i < DEPTH; i++) begin
            cycle[i]     = value_t'($urandom_range(2000, 8000));
            tgt_duty[i]  = value_t'($urandom_range(0, int'(cycle[i]) / 2));
            tgt_phase[i] = value_t'($urandom_range(0, int'(cycle[i]) - 1));
        end
        send_frames(41);
        bad_d = 0;
        bad_p = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cap_duty[i] !== tgt_duty[i]) bad_d++;
            if (cap_phase[i] !== tgt_phase[i]) bad_p++;
        end
        check("conv_duty_bad", bad_d, 0);
        check("conv_phase_bad", bad_p, 0);
        check("conv_run_len", run_len, 41 * DEPTH);
        check("conv_latency", first_rise - t_in, EXP_LAT);

        // Reset in the middle of a frame flushes the pipeline
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            din_valid = 1'b1;
            duty      = tgt_duty[i];
            phase     = tgt_phase[i];
        end
        @(negedge clk);
        rst = 1'b1;
        din_valid = 1'b0;
        @(negedge clk);
        snap = valid_total;
        idle(2);
        rst = 1'b0;
        idle(EXP_LAT + 5);
        check("flush_no_valid", valid_total - snap, 0);
        check("flush_duty", int'(duty_s), 0);
        check("flush_phase", int'(phase_s), 0);

        // Duty ramp from zero state
        set_cycle(2000);
        frame_check("duty_1", 100, 350, 0, 100, 0);
        frame_check("duty_2", 100, 350, 0, 200, 0);
        frame_check("duty_3", 100, 350, 0, 300, 0);
        frame_check("duty_4", 100, 350, 0, 350, 0);
        frame_check("duty_5", 100, 350, 0, 350, 0);

        // Forward phase wrap through zero
        frame_check("setup_1950", 8191, 0, 1950, 0, 1950);
        frame_check("wrap_1", 30, 0, 50, 0, 1980);
        frame_check("wrap_2", 30, 0, 50, 0, 10);
        frame_check("wrap_3", 30, 0, 50, 0, 40);
        frame_check("wrap_4", 30, 0, 50, 0, 50);

        // Backward phase step, with duty stepping down
        frame_check("setup_100", 8191, 500, 100, 500, 100);
        frame_check("back_1", 150, 200, 1900, 350, 1950);
        frame_check("back_2", 150, 200, 1900, 200, 1900);

        // Tie goes forward; shrinking CYCLE uses the true remainder
        frame_check("setup_0", 8191, 200, 0, 200, 0);
        frame_check("tie", 400, 200, 1000, 200, 400);
        set_cycle(8000);
        frame_check("setup_7000", 8191, 200, 7000, 200, 7000);
        set_cycle(2000);
        frame_check("shrink", 8191, 200, 0, 200, 0);
        frame_check("tgt_mod", 8191, 200, 4100, 200, 100);
        frame_check("step0_hold", 0, 4000, 1500, 200, 100);

        // Filter disabled: one frame lands on every target
        step = value_t'(16'hFFFF);
        for (int i = 0; i < DEPTH; i++) begin
            cycle[i]     = value_t'($urandom_range(2, 8191));
            tgt_duty[i]  = value_t'($urandom_range(0, 8191));
            tgt_phase[i] = value_t'($urandom_range(0, int'(cycle[i]) - 1));
        end
        send_frames(1);
        bad_d = 0;
        bad_p = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cap_duty[i] !== tgt_duty[i]) bad_d++;
            if (cap_phase[i] !== tgt_phase[i]) bad_p++;
        end
        check("bypass_duty_bad", bad_d, 0);
        check("bypass_phase_bad", bad_p, 0);
        check("bypass_latency", first_rise - t_in, EXP_LAT);
        check("bypass_run_len", run_len, DEPTH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
